// File: rtl/sdp_wdma_gather_pack_pkg.sv
`default_nettype none
// =============================================================================
// Module      : sdp_wdma_pkg
// Description : Shared types and elaboration helpers for the SDP WDMA pack stage.
// Revision    : 1.0 - initial release
// =============================================================================
package sdp_wdma_pkg;

    typedef enum logic {
        DP16 = 1'b0,
        DP8  = 1'b1
    } dp_mode_e;

    function automatic bit ratio_legal(input int ratio);
        return (ratio == 1) || (ratio == 2) || (ratio == 4) || (ratio == 8);
    endfunction

    function automatic int sc_width(input int nslot);
        return $clog2(nslot + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_wdma_gather_pack_if.sv
`default_nettype none
// =============================================================================
// Module      : sdp_wdma_gather_pack_if
// Description : Input beat / output word handshake bundle for the pack stage.
// Revision    : 1.0 - initial release
// =============================================================================
interface sdp_wdma_gather_pack_if #(
    parameter int IW = 64,
    parameter int OW = 256
);
    localparam int NSLOT = 2 * (OW / IW);

    logic             cfg_dp_8;
    logic             inp_pvld;
    logic             inp_prdy;
    logic [IW-1:0]    inp_data;
    logic             inp_last;
    logic             out_pvld;
    logic             out_prdy;
    logic [OW-1:0]    out_data;
    logic [NSLOT-1:0] out_mask;
    logic             out_last;

    modport master (
        output cfg_dp_8, inp_pvld, inp_data, inp_last, out_prdy,
        input  inp_prdy, out_pvld, out_data, out_mask, out_last
    );

    modport slave (
        input  cfg_dp_8, inp_pvld, inp_data, inp_last, out_prdy,
        output inp_prdy, out_pvld, out_data, out_mask, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sdp_wdma_pack_oreg.sv
`default_nettype none
// =============================================================================
// Module      : sdp_wdma_pack_oreg
// Description : One-entry valid/ready holding register for completed words.
// Revision    : 1.0 - initial release
// =============================================================================
module sdp_wdma_pack_oreg #(
    parameter int W = 265
) (
    input  wire logic         nvdla_core_clk,
    input  wire logic         nvdla_core_rstn,
    input  wire logic         in_vld,
    output logic              in_rdy,
    input  wire logic [W-1:0] in_data,
    output logic              out_vld,
    input  wire logic         out_rdy,
    output logic [W-1:0]      out_data
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    // Accepting while popping keeps a word per cycle flowing with no bubble.
    assign in_rdy   = !vld_q || out_rdy;
    assign out_vld  = vld_q;
    assign out_data = data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (in_vld && in_rdy) begin
            vld_d  = 1'b1;
            data_d = in_data;
        end else if (out_rdy) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sdp_wdma_gather_pack.sv
`default_nettype none
// =============================================================================
// Module      : sdp_wdma_gather_pack
// Description : Gathers IW-bit beats (16-bit or 8-bit mode) into OW-bit DMA words.
// Revision    : 1.0 - initial release
// =============================================================================
module sdp_wdma_gather_pack
    import sdp_wdma_pkg::*;
#(
    parameter int IW = 64,
    parameter int OW = 256
) (
    input  wire logic              nvdla_core_clk,
    input  wire logic              nvdla_core_rstn,
    sdp_wdma_gather_pack_if.slave  bus
);
    localparam int RATIO = OW / IW;
    localparam int NSLOT = 2 * RATIO;
    localparam int HW    = IW / 2;
    localparam int SCW   = sc_width(NSLOT);
    localparam int WW    = OW + NSLOT + 1;

    generate
        if (!ratio_legal(RATIO) || (OW != IW * RATIO) || (IW < 16) || (IW % 2 != 0)) begin : g_bad_params
            $error("sdp_wdma_gather_pack: illegal IW/OW combination");
        end
    endgenerate

    logic [OW-1:0]    acc_data_q, acc_data_d;
    logic [NSLOT-1:0] acc_mask_q, acc_mask_d;
    logic [SCW-1:0]   acc_sc_q, acc_sc_d;
    logic             acc_last_q, acc_last_d;
    dp_mode_e         mode_q, mode_d;
    logic             pending_q, pending_d;

    logic             oreg_in_rdy;
    logic             oreg_in_vld;
    logic [WW-1:0]    oreg_in_word;
    logic [WW-1:0]    oreg_out_word;
    logic             inp_fire;
    logic [OW-1:0]    m_data;
    logic [NSLOT-1:0] m_mask;
    logic [SCW-1:0]   base_sc;
    logic [SCW-1:0]   new_sc;
    dp_mode_e         w_mode;
    logic             complete;
    logic             take_new;

    // A pending word leaves whenever the output register frees, so ready may follow out_prdy.
    assign bus.inp_prdy = !pending_q || oreg_in_rdy;
    assign inp_fire     = bus.inp_pvld && bus.inp_prdy;

    always_comb begin
        // An accepted beat during a pending cycle lands in an accumulator being cleared.
        m_data  = pending_q ? '0 : acc_data_q;
        m_mask  = pending_q ? '0 : acc_mask_q;
        base_sc = pending_q ? '0 : acc_sc_q;
        w_mode  = (base_sc == '0) ? dp_mode_e'(bus.cfg_dp_8) : mode_q;
        for (int s = 0; s < NSLOT; s++) begin
            if (s == int'(base_sc)) begin
                m_data[s*HW +: HW] = bus.inp_data[HW-1:0];
                m_mask[s]          = 1'b1;
            end else if ((w_mode == DP16) && (s == int'(base_sc) + 1)) begin
                m_data[s*HW +: HW] = bus.inp_data[IW-1:HW];
                m_mask[s]          = 1'b1;
            end
        end
        new_sc   = base_sc + ((w_mode == DP16) ? SCW'(2) : SCW'(1));
        complete = inp_fire && ((new_sc == SCW'(NSLOT)) || bus.inp_last);

        oreg_in_vld  = pending_q || complete;
        oreg_in_word = pending_q ? {acc_last_q, acc_mask_q, acc_data_q}
                                 : {bus.inp_last, m_mask, m_data};
        take_new     = !pending_q && complete && oreg_in_rdy;

        acc_data_d = acc_data_q;
        acc_mask_d = acc_mask_q;
        acc_sc_d   = acc_sc_q;
        acc_last_d = acc_last_q;
        mode_d     = mode_q;
        pending_d  = pending_q;
        if (pending_q && oreg_in_rdy) begin
            acc_data_d = '0;
            acc_mask_d = '0;
            acc_sc_d   = '0;
            acc_last_d = 1'b0;
            pending_d  = 1'b0;
        end
        if (inp_fire) begin
            if (take_new) begin
                acc_data_d = '0;
                acc_mask_d = '0;
                acc_sc_d   = '0;
                acc_last_d = 1'b0;
            end else begin
                acc_data_d = m_data;
                acc_mask_d = m_mask;
                acc_sc_d   = new_sc;
                acc_last_d = bus.inp_last;
                mode_d     = w_mode;
                pending_d  = complete;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            acc_data_q <= '0;
            acc_mask_q <= '0;
            acc_sc_q   <= '0;
            acc_last_q <= 1'b0;
            mode_q     <= DP16;
            pending_q  <= 1'b0;
        end else begin
            acc_data_q <= acc_data_d;
            acc_mask_q <= acc_mask_d;
            acc_sc_q   <= acc_sc_d;
            acc_last_q <= acc_last_d;
            mode_q     <= mode_d;
            pending_q  <= pending_d;
        end
    end

    sdp_wdma_pack_oreg #(.W(WW)) u_oreg (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .in_vld          (oreg_in_vld),
        .in_rdy          (oreg_in_rdy),
        .in_data         (oreg_in_word),
        .out_vld         (bus.out_pvld),
        .out_rdy         (bus.out_prdy),
        .out_data        (oreg_out_word)
    );

    assign bus.out_data = oreg_out_word[OW-1:0];
    assign bus.out_mask = oreg_out_word[OW +: NSLOT];
    assign bus.out_last = oreg_out_word[WW-1];
endmodule
`default_nettype wire
